lfsr_uart_tx: RTL and testbench

LFSR_UART_TX -- requirements
Module: lfsr_uart_tx

---
 rtl/lfsr_uart_pkg.sv | 14 +
 rtl/lfsr_uart_tx_baud.sv | 29 ++
 rtl/lfsr_uart_tx.sv | 113 +++++++++++
 tb/tb_lfsr_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_uart_pkg.sv
// Shared FSM encoding and framing constants for the LFSR UART transmitter.
package lfsr_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int FRAME_BITS    = 10;

endpackage

// File: rtl/lfsr_uart_tx_baud.sv
// Bit-period counter: one-cycle tick every CLKS_PER_BIT enabled cycles.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Held at zero while disabled so every bit period starts fresh.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/lfsr_uart_tx.sv
// 8N1 serializer for the LFSR packer word, MSB byte first, bits LSB first.
module lfsr_uart_tx
  import lfsr_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [63:0] data_in,
  output logic        ready,
  output logic        tx,
  output logic        done,
  output logic [2:0]  byte_idx
);

  localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);
  localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);

  state_t      state, state_n;
  logic [63:0] shreg, shreg_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [2:0]  idx_n;
  logic        done_n;
  logic        tick;
  logic        baud_en;
  logic [7:0]  cur_byte;

  assign baud_en  = (state != IDLE);
  assign cur_byte = shreg[63:56];
  assign ready    = (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .clr (clr),
    .en  (baud_en),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      byte_idx <= idx_n;
      done     <= done_n;
    end
  end

  // tx is decoded from state so clr forces the line idle immediately.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    idx_n     = byte_idx;
    done_n    = 1'b0;
    tx        = 1'b1;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = START_BIT;
          shreg_n   = data_in;
          bit_cnt_n = '0;
          idx_n     = '0;
        end
      end
      START_BIT: begin
        tx = 1'b0;
        if (tick) begin
          state_n = DATA_BITS;
        end
      end
      DATA_BITS: begin
        tx = cur_byte[bit_cnt];
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_n   = STOP_BIT;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      STOP_BIT: begin
        if (tick) begin
          if (byte_idx == LAST_BYTE) begin
            state_n = IDLE;
            idx_n   = '0;
            shreg_n = '0;
            done_n  = 1'b1;
          end else begin
            state_n = START_BIT;
            idx_n   = byte_idx + 3'd1;
            shreg_n = {shreg[55:0], 8'h00};
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lfsr_uart_tx.sv
// Bench for lfsr_uart_tx: table-driven frames checked cycle by cycle against a waveform model.
`timescale 1ns/1ps
module tb_lfsr_uart_tx;
  import lfsr_uart_pkg::*;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        start_v [NI];
  logic [63:0] data_v  [NI];
  logic        ready_v [NI];
  logic        tx_v    [NI];
  logic        done_v  [NI];
  logic [2:0]  idx_v   [NI];

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  lfsr_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(8)) u0 (
    .clk(clk), .clr(clr), .start(start_v[0]), .data_in(data_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .done(done_v[0]), .byte_idx(idx_v[0]));
  lfsr_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(1)) u1 (
    .clk(clk), .clr(clr), .start(start_v[1]), .data_in(data_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .done(done_v[1]), .byte_idx(idx_v[1]));
  lfsr_uart_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(8)) u2 (
    .clk(clk), .clr(clr), .start(start_v[2]), .data_in(data_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .done(done_v[2]), .byte_idx(idx_v[2]));
  lfsr_uart_tx #(.CLKS_PER_BIT(434), .NUM_BYTES(8)) u3 (
    .clk(clk), .clr(clr), .start(start_v[3]), .data_in(data_v[3]),
    .ready(ready_v[3]), .tx(tx_v[3]), .done(done_v[3]), .byte_idx(idx_v[3]));

  function automatic int cpb_of(input int i);
    case (i)
      2:       return 2;
      3:       return 434;
      default: return 4;
    endcase
  endfunction

  function automatic int nb_of(input int i);
    return (i == 1) ? 1 : 8;
  endfunction

  function automatic logic [7:0] byte_of(input logic [63:0] d, input int b);
    return d[63-8*b -: 8];
  endfunction

  // Expected line level k cycles after the first start-bit cycle.
  function automatic logic exp_tx(input logic [63:0] d, input int cpb, input int k);
    int per;
    int pos;
    logic [7:0] by;
    per = FRAME_BITS * cpb;
    pos = (k % per) / cpb;
    by  = byte_of(d, k / per);
    if (pos == 0) return 1'b0;
    if (pos == FRAME_BITS - 1) return 1'b1;
    return by[pos-1];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic accept(input int i, input logic [63:0] d, input bit hold);
    check("ready before start", ready_v[i], 1'b1);
    start_v[i] = 1'b1;
    data_v[i]  = d;
    @(posedge clk);
    #1 start_v[i] = hold;
  endtask

  // Checks every cycle from the first start bit to the done cycle and decodes bytes.
  task automatic check_frame(input int i, input logic [63:0] d, input bit mid_ff);
    int cpb;
    int per;
    int total;
    int run;
    int pos;
    logic prev;
    logic [7:0] cur;
    cpb   = cpb_of(i);
    per   = FRAME_BITS * cpb;
    total = nb_of(i) * per;
    run   = -1;
    prev  = 1'b1;
    cur   = '0;
    rx_q.delete();
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      if (mid_ff && k == total / 2) data_v[i] = '1;
      if (k < total) begin
        check("tx level", tx_v[i], exp_tx(d, cpb, k));
        check("byte_idx", idx_v[i], 64'(k / per));
        check("ready busy", ready_v[i], 1'b0);
        check("done early", done_v[i], 1'b0);
        if (tx_v[i] !== prev) begin
          if (run > 0) check("run length mod cpb", 64'(run % cpb), 0);
          run  = 1;
          prev = tx_v[i];
        end else if (run > 0) begin
          run++;
        end
        if (k % cpb == cpb / 2) begin
          pos = (k % per) / cpb;
          if (pos >= 1 && pos <= BITS_PER_BYTE) cur[pos-1] = tx_v[i];
          if (pos == FRAME_BITS - 1) rx_q.push_back(cur);
        end
      end else begin
        check("done pulse", done_v[i], 1'b1);
        check("ready at done", ready_v[i], 1'b1);
        check("byte_idx at done", idx_v[i], 0);
        check("tx idle at done", tx_v[i], 1'b1);
      end
    end
  endtask

  task automatic check_bytes(input int i, input logic [63:0] d);
    check("rx byte count", 64'(rx_q.size()), 64'(nb_of(i)));
    for (int j = 0; j < rx_q.size(); j++)
      check("rx byte", rx_q[j], byte_of(d, j));
  endtask

  typedef struct {
    logic [63:0] data;
    logic [7:0]  first;
    logic [7:0]  last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [63:0] d;
    tbl[0] = '{64'hE0C0A08060402001, 8'hE0, 8'h01};
    tbl[1] = '{64'h0000000000000000, 8'h00, 8'h00};
    tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF};
    tbl[3] = '{64'h0123456789ABCDEF, 8'h01, 8'hEF};
    for (int t = 4; t < 6; t++) begin
      tbl[t].data  = {$urandom, $urandom};
      tbl[t].first = byte_of(tbl[t].data, 0);
      tbl[t].last  = byte_of(tbl[t].data, 7);
    end

    clr = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      data_v[i]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset tx", tx_v[i], 1'b1);
      check("reset ready", ready_v[i], 1'b1);
      check("reset done", done_v[i], 1'b0);
      check("reset byte_idx", idx_v[i], 0);
    end
    clr = 1'b0;

    // Back-to-back table frames: each starts in the previous done cycle.
    for (int t = 0; t < 6; t++) begin
      accept(0, tbl[t].data, 1'b0);
      check_frame(0, tbl[t].data, 1'b0);
      check_bytes(0, tbl[t].data);
      if (rx_q.size() == 8) begin
        check("table first byte", rx_q[0], tbl[t].first);
        check("table last byte", rx_q[7], tbl[t].last);
      end
    end

    // start held through the frame, data changed mid-frame.
    repeat (3) @(negedge clk);
    accept(0, 64'hE0C0A08060402001, 1'b1);
    check_frame(0, 64'hE0C0A08060402001, 1'b1);
    check_bytes(0, 64'hE0C0A08060402001);
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    check_frame(0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    check_bytes(0, 64'hFFFFFFFFFFFFFFFF);

    // Abort during a data bit of byte 3 while the line is low.
    repeat (2) @(negedge clk);
    accept(0, 64'hE0C0A08060402001, 1'b0);
    for (int k = 0; k <= 129; k++) begin
      @(negedge clk);
      check("pre-abort tx", tx_v[0], exp_tx(64'hE0C0A08060402001, 4, k));
    end
    check("pre-abort byte_idx", idx_v[0], 3);
    #1 clr = 1'b1;
    #1;
    check("abort tx async", tx_v[0], 1'b1);
    check("abort ready async", ready_v[0], 1'b1);
    check("abort byte_idx async", idx_v[0], 0);
    check("abort done", done_v[0], 1'b0);
    @(negedge clk) clr = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      check("post-abort tx", tx_v[0], 1'b1);
      check("post-abort ready", ready_v[0], 1'b1);
      check("post-abort done", done_v[0], 1'b0);
      check("post-abort byte_idx", idx_v[0], 0);
    end

    // start waiting under clr is taken on the first edge after release.
    d = {$urandom, $urandom};
    clr = 1'b1;
    start_v[0] = 1'b1;
    data_v[0]  = d;
    @(posedge clk);
    #2;
    check("no accept in clr", ready_v[0], 1'b1);
    check("tx idle in clr", tx_v[0], 1'b1);
    @(negedge clk) clr = 1'b0;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    check_frame(0, d, 1'b0);
    check_bytes(0, d);

    // Single-byte frame.
    @(negedge clk);
    d = {8'hA5, 24'($urandom), $urandom};
    accept(1, d, 1'b0);
    check_frame(1, d, 1'b0);
    check_bytes(1, d);
    if (rx_q.size() == 1) check("single byte A5", rx_q[0], 8'hA5);

    // Shortest and default bit periods.
    @(negedge clk);
    d = {$urandom, $urandom};
    accept(2, d, 1'b0);
    check_frame(2, d, 1'b0);
    check_bytes(2, d);

    @(negedge clk);
    d = {$urandom, $urandom};
    accept(3, d, 1'b0);
    check_frame(3, d, 1'b0);
    check_bytes(3, d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
